classify_layer_seq: RTL and testbench

- Time-multiplexed sequencer for the classification layer; one signed multiplier-accumulator is shared across all out_dim neurons.
- Computes Output[j] = sat(((bias[j] << FRAC_BITS) + sum_i hv[i]*W[i][j]) >>> FRAC_BITS).
- Reads hidden vector, weights and biases from external synchronous RAMs; writes each result to an output buffer.
- Sits after the hidden layer and is driven by the top-level RBM control FSM through a start/done handshake.

---
 rtl/classify_layer_seq_pkg.sv | 41 ++++
 rtl/classify_layer_seq_mac_sat.sv | 64 ++++++
 rtl/classify_layer_seq.sv | 168 ++++++++++++++++
 tb/tb_classify_layer_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/classify_layer_seq_pkg.sv
// Shared definitions for the classification-layer sequencer:
// FSM state encoding, width helpers and saturation bounds.
package classify_layer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Address/index width, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Accumulator width: full product plus enough guard bits for in_dim terms and the bias.
    function automatic int acc_w(input int in_bits, input int n_terms);
        return 2 * in_bits + clog2(n_terms + 1) + 1;
    endfunction

    function automatic longint sat_max(input int out_bits);
        return (longint'(1) <<< (out_bits - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int out_bits);
        return -(longint'(1) <<< (out_bits - 1));
    endfunction

endpackage

// File: rtl/classify_layer_seq_mac_sat.sv
// Signed multiply-accumulate with bias preload, arithmetic fraction shift
// and output saturation for the classification-layer sequencer.
module classify_mac_sat
    import classify_layer_seq_pkg::*;
#(
    parameter int input_bitlength  = 12,
    parameter int output_bitlength = 8,
    parameter int in_dim           = 5,
    parameter int FRAC_BITS        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mac_en,
    input  logic                        mac_first,
    input  logic [input_bitlength-1:0]  b_data,
    input  logic [input_bitlength-1:0]  hv_data,
    input  logic [input_bitlength-1:0]  w_data,
    output logic [output_bitlength-1:0] sat_out
);

    localparam int ACC_W = acc_w(input_bitlength, in_dim);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(output_bitlength));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(output_bitlength));

    logic signed [2*input_bitlength-1:0] product;
    logic signed [ACC_W-1:0]             product_ext;
    logic signed [ACC_W-1:0]             bias_ext;
    logic signed [ACC_W-1:0]             acc_reg;
    logic signed [ACC_W-1:0]             acc_next;
    logic signed [ACC_W-1:0]             shifted;

    assign product     = $signed(hv_data) * $signed(w_data);
    assign product_ext = ACC_W'(product);
    assign bias_ext    = ACC_W'($signed(b_data)) <<< FRAC_BITS;

    // First term of a neuron starts from the scaled bias; later terms add onto the running sum.
    always_comb begin
        acc_next = acc_reg + product_ext;
        if (mac_first) begin
            acc_next = bias_ext + product_ext;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (mac_en) begin
            acc_reg <= acc_next;
        end
    end

    // Drop fraction bits (arithmetic) and clamp into the signed output range.
    always_comb begin
        shifted = acc_reg >>> FRAC_BITS;
        sat_out = shifted[output_bitlength-1:0];
        if (shifted > SAT_HI) begin
            sat_out = SAT_HI[output_bitlength-1:0];
        end else if (shifted < SAT_LO) begin
            sat_out = SAT_LO[output_bitlength-1:0];
        end
    end

endmodule

// File: rtl/classify_layer_seq.sv
// Time-multiplexed classification layer: one shared MAC computes every output
// neuron from external synchronous RAMs and writes results to an output buffer.
// Optional argmax tracking is enabled by defining CLASSIFY_ARGMAX_EN.
module classify_layer_seq
    import classify_layer_seq_pkg::*;
#(
    parameter int input_bitlength  = 12,
    parameter int output_bitlength = 8,
    parameter int in_dim           = 5,
    parameter int out_dim          = 2,
    parameter int FRAC_BITS        = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [addr_w(in_dim)-1:0]           hv_addr,
    input  logic [input_bitlength-1:0]          hv_data,
    output logic [addr_w(in_dim*out_dim)-1:0]   w_addr,
    input  logic [input_bitlength-1:0]          w_data,
    output logic [addr_w(out_dim)-1:0]          b_addr,
    input  logic [input_bitlength-1:0]          b_data,
    output logic                                out_we,
    output logic [addr_w(out_dim)-1:0]          out_addr,
    output logic [output_bitlength-1:0]         out_data,
    output logic [addr_w(out_dim)-1:0]          class_idx
);

    localparam int HV_AW = addr_w(in_dim);
    localparam int W_AW  = addr_w(in_dim * out_dim);
    localparam int J_W   = addr_w(out_dim);
    localparam int K_W   = addr_w(in_dim);

    state_t                      state_reg, state_next;
    logic [K_W-1:0]              k_reg, k_next;
    logic [J_W-1:0]              j_reg, j_next;
    logic [output_bitlength-1:0] out_data_reg;
    logic [output_bitlength-1:0] mac_result;
    logic                        mac_en;
    logic                        mac_first;

    classify_mac_sat #(
        .input_bitlength (input_bitlength),
        .output_bitlength(output_bitlength),
        .in_dim          (in_dim),
        .FRAC_BITS       (FRAC_BITS)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .mac_en   (mac_en),
        .mac_first(mac_first),
        .b_data   (b_data),
        .hv_data  (hv_data),
        .w_data   (w_data),
        .sat_out  (mac_result)
    );

    // State, counters and the held copy of the last written result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            k_reg        <= '0;
            j_reg        <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            j_reg     <= j_next;
            if (state_reg == ST_WRITE) begin
                out_data_reg <= mac_result;
            end
        end
    end

    // Next-state, address generation and strobes; RAM addresses lead their data by one cycle.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        j_next     = j_reg;
        mac_en     = 1'b0;
        mac_first  = 1'b0;
        hv_addr    = '0;
        w_addr     = '0;
        b_addr     = '0;
        out_we     = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    j_next     = '0;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy       = 1'b1;
                hv_addr    = '0;
                w_addr     = W_AW'(j_reg);
                b_addr     = j_reg;
                k_next     = '0;
                state_next = ST_MAC;
            end
            ST_MAC: begin
                busy      = 1'b1;
                mac_en    = 1'b1;
                mac_first = (k_reg == '0);
                if (k_reg != K_W'(in_dim - 1)) begin
                    k_next  = k_reg + 1'b1;
                    hv_addr = HV_AW'(k_reg + 1'b1);
                    w_addr  = W_AW'((32'(k_reg) + 32'd1) * 32'(out_dim) + 32'(j_reg));
                    b_addr  = j_reg;
                end else begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy   = 1'b1;
                out_we = 1'b1;
                if (j_reg != J_W'(out_dim - 1)) begin
                    j_next     = j_reg + 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign out_addr = j_reg;
    assign out_data = (state_reg == ST_WRITE) ? mac_result : out_data_reg;

`ifdef CLASSIFY_ARGMAX_EN
    logic signed [output_bitlength-1:0] max_reg;
    logic [J_W-1:0]                     best_reg;
    logic [J_W-1:0]                     class_idx_reg;

    // Running maximum over written outputs; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_reg       <= '0;
            best_reg      <= '0;
            class_idx_reg <= '0;
        end else begin
            if (state_reg == ST_WRITE &&
                (j_reg == '0 || $signed(mac_result) > max_reg)) begin
                max_reg  <= $signed(mac_result);
                best_reg <= j_reg;
            end
            if (state_reg == ST_DONE) begin
                class_idx_reg <= best_reg;
            end
        end
    end

    assign class_idx = class_idx_reg;
`else
    assign class_idx = '0;
`endif

endmodule

// File: tb/tb_classify_layer_seq.sv
// Testbench for classify_layer_seq: two instances (FRAC_BITS 0 and 4) share the
// same RAM contents; directed vectors with hand-computed results plus sequences
// for start-while-busy and reset mid-operation.
module tb_classify_layer_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [11:0] hv_mem [5];
    logic [11:0] w_mem  [10];
    logic [11:0] b_mem  [2];

    logic       busy_a     [2];
    logic       done_a     [2];
    logic       out_we_a   [2];
    logic [2:0] hv_addr_a  [2];
    logic [3:0] w_addr_a   [2];
    logic [0:0] b_addr_a   [2];
    logic [0:0] out_addr_a [2];
    logic [7:0] out_data_a [2];
    logic [0:0] class_idx_a[2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [11:0] hv_q;
        logic [11:0] w_q;
        logic [11:0] b_q;

        always @(posedge clk) begin
            hv_q <= hv_mem[hv_addr_a[gi]];
            w_q  <= w_mem[w_addr_a[gi]];
            b_q  <= b_mem[b_addr_a[gi]];
        end

        classify_layer_seq #(
            .input_bitlength (12),
            .output_bitlength(8),
            .in_dim          (5),
            .out_dim         (2),
            .FRAC_BITS       (gi * 4)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .busy     (busy_a[gi]),
            .done     (done_a[gi]),
            .hv_addr  (hv_addr_a[gi]),
            .hv_data  (hv_q),
            .w_addr   (w_addr_a[gi]),
            .w_data   (w_q),
            .b_addr   (b_addr_a[gi]),
            .b_data   (b_q),
            .out_we   (out_we_a[gi]),
            .out_addr (out_addr_a[gi]),
            .out_data (out_data_a[gi]),
            .class_idx(class_idx_a[gi])
        );
    end

    typedef struct {
        string name;
        int    hv[5];
        int    w0[5];
        int    w1[5];
        int    b[2];
        int    exp_out[2][2];   // [instance][neuron]
        int    exp_idx[2];      // argmax per instance when enabled
    } vec_t;

    vec_t vecs[5];

    int tests = 0;
    int fails = 0;

    int wr_n[2];
    int wr_addr[2][4];
    int wr_data[2][4];
    int wr_cyc[2][4];
    int done_n[2];
    int done_cyc[2];
    int busy_c1[2];
    int busy_after_rst[2];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 5; i++) begin
            hv_mem[i]       = 12'(v.hv[i]);
            w_mem[i * 2]    = 12'(v.w0[i]);
            w_mem[i * 2 + 1] = 12'(v.w1[i]);
        end
        b_mem[0] = 12'(v.b[0]);
        b_mem[1] = 12'(v.b[1]);
    endtask

    // Start in cycle 0, then observe ncyc cycles; optional extra start pulses and a reset pulse.
    task automatic run_txn(input int pa, input int pb, input int rst_at, input int ncyc);
        for (int f = 0; f < 2; f++) begin
            wr_n[f] = 0;
            done_n[f] = 0;
            done_cyc[f] = -1;
            busy_c1[f] = 0;
            busy_after_rst[f] = -1;
        end
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            for (int f = 0; f < 2; f++) begin
                if (out_we_a[f] && wr_n[f] < 4) begin
                    wr_addr[f][wr_n[f]] = int'(out_addr_a[f]);
                    wr_data[f][wr_n[f]] = int'($signed(out_data_a[f]));
                    wr_cyc[f][wr_n[f]]  = c;
                    wr_n[f]++;
                end
                if (done_a[f]) begin
                    done_n[f]++;
                    done_cyc[f] = c;
                end
                if (c == 1) busy_c1[f] = int'(busy_a[f]);
                if (rst_at > 0 && c == rst_at + 1) busy_after_rst[f] = int'(busy_a[f]);
            end
            start = (c == pa) || (c == pb);
            reset = (rst_at > 0) && (c == rst_at);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_txn(input vec_t v);
        int exp_idx;
        for (int f = 0; f < 2; f++) begin
            string tag;
            tag = $sformatf("%s.f%0d", v.name, f * 4);
            chk({tag, ".writes"}, wr_n[f], 2);
            chk({tag, ".busy_load"}, busy_c1[f], 1);
            chk({tag, ".addr0"}, wr_addr[f][0], 0);
            chk({tag, ".data0"}, wr_data[f][0], v.exp_out[f][0]);
            chk({tag, ".cyc0"}, wr_cyc[f][0], 7);
            chk({tag, ".addr1"}, wr_addr[f][1], 1);
            chk({tag, ".data1"}, wr_data[f][1], v.exp_out[f][1]);
            chk({tag, ".cyc1"}, wr_cyc[f][1], 14);
            chk({tag, ".done_n"}, done_n[f], 1);
            chk({tag, ".done_cyc"}, done_cyc[f], 15);
`ifdef CLASSIFY_ARGMAX_EN
            exp_idx = v.exp_idx[f];
`else
            exp_idx = 0;
`endif
            chk({tag, ".class_idx"}, int'(class_idx_a[f]), exp_idx);
            $display("[TB] txn %s: out=(%0d,%0d) done@%0d class_idx=%0d",
                     tag, wr_data[f][0], wr_data[f][1], done_cyc[f], class_idx_a[f]);
        end
    endtask

    initial begin
        vecs[0].name = "basic";
        vecs[0].hv = '{1, 1, 1, 1, 1};
        vecs[0].w0 = '{1, 1, 1, 1, 1};
        vecs[0].w1 = '{2, 2, 2, 2, 2};
        vecs[0].b = '{0, 0};
        vecs[0].exp_out = '{'{5, 10}, '{0, 0}};
        vecs[0].exp_idx = '{1, 0};

        vecs[1].name = "bias_frac";
        vecs[1].hv = '{16, 16, 16, 16, 16};
        vecs[1].w0 = '{16, 16, 16, 16, 16};
        vecs[1].w1 = '{16, 16, 16, 16, 16};
        vecs[1].b = '{3, -2};
        vecs[1].exp_out = '{'{127, 127}, '{83, 78}};
        vecs[1].exp_idx = '{0, 0};

        vecs[2].name = "saturate";
        vecs[2].hv = '{100, 100, 100, 100, 100};
        vecs[2].w0 = '{100, 100, 100, 100, 100};
        vecs[2].w1 = '{-100, -100, -100, -100, -100};
        vecs[2].b = '{0, 0};
        vecs[2].exp_out = '{'{127, -128}, '{127, -128}};
        vecs[2].exp_idx = '{0, 0};

        vecs[3].name = "tie";
        vecs[3].hv = '{1, 2, 3, 4, 5};
        vecs[3].w0 = '{-1, 0, 2, 1, -3};
        vecs[3].w1 = '{-1, 0, 2, 1, -3};
        vecs[3].b = '{0, 0};
        vecs[3].exp_out = '{'{-6, -6}, '{-1, -1}};
        vecs[3].exp_idx = '{0, 0};

        vecs[4].name = "mixed";
        vecs[4].hv = '{3, -2, 5, 0, 7};
        vecs[4].w0 = '{2, 4, -1, 9, 1};
        vecs[4].w1 = '{-3, 1, 2, 5, 4};
        vecs[4].b = '{-7, 20};
        vecs[4].exp_out = '{'{-7, 47}, '{-7, 21}};
        vecs[4].exp_idx = '{1, 1};

        load_vec(vecs[0]);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        for (int f = 0; f < 2; f++) begin
            chk($sformatf("rst.f%0d.busy", f * 4), int'(busy_a[f]), 0);
            chk($sformatf("rst.f%0d.done", f * 4), int'(done_a[f]), 0);
            chk($sformatf("rst.f%0d.out_we", f * 4), int'(out_we_a[f]), 0);
            chk($sformatf("rst.f%0d.hv_addr", f * 4), int'(hv_addr_a[f]), 0);
            chk($sformatf("rst.f%0d.w_addr", f * 4), int'(w_addr_a[f]), 0);
            chk($sformatf("rst.f%0d.b_addr", f * 4), int'(b_addr_a[f]), 0);
            chk($sformatf("rst.f%0d.out_data", f * 4), int'(out_data_a[f]), 0);
            chk($sformatf("rst.f%0d.class_idx", f * 4), int'(class_idx_a[f]), 0);
        end

        // Directed vectors
        for (int v = 0; v < 5; v++) begin
            load_vec(vecs[v]);
            run_txn(0, 0, 0, 20);
            check_txn(vecs[v]);
        end

        // Start pulses while busy are ignored
        load_vec(vecs[0]);
        run_txn(3, 9, 0, 20);
        check_txn(vecs[0]);

        // Reset mid-operation: class_idx currently holds the basic-vector result
        load_vec(vecs[4]);
        run_txn(0, 0, 7, 20);
        for (int f = 0; f < 2; f++) begin
            chk($sformatf("midrst.f%0d.writes", f * 4), wr_n[f], 1);
            chk($sformatf("midrst.f%0d.done_n", f * 4), done_n[f], 0);
            chk($sformatf("midrst.f%0d.busy", f * 4), busy_after_rst[f], 0);
            chk($sformatf("midrst.f%0d.class_idx", f * 4), int'(class_idx_a[f]), 0);
            $display("[TB] txn midrst.f%0d: writes=%0d done=%0d busy_after=%0d",
                     f * 4, wr_n[f], done_n[f], busy_after_rst[f]);
        end
        run_txn(0, 0, 0, 20);
        check_txn(vecs[4]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
